// File: rtl/cell_bist_pkg.sv
// Shared types and the MISR update rule for the cell_bist self-test harness.
package cell_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int unsigned     SIG_W_MAX    = 64;
    localparam logic [15:0]     DEFAULT_POLY = 16'hB400;

    // One MISR shift of a width-bit register held in the low bits of a SIG_W_MAX vector.
    function automatic logic [SIG_W_MAX-1:0] misr_step(
        input logic [SIG_W_MAX-1:0] sig,
        input logic                 y,
        input logic [SIG_W_MAX-1:0] poly,
        input int                   width = 16
    );
        logic [SIG_W_MAX-1:0] mask;
        logic [SIG_W_MAX-1:0] top_bit;
        logic [SIG_W_MAX-1:0] nxt;
        mask    = (SIG_W_MAX'(1) << width) - SIG_W_MAX'(1);
        top_bit = sig >> (width - 1);
        nxt     = (sig << 1) ^ {{(SIG_W_MAX-1){1'b0}}, y};
        if (top_bit[0]) begin
            nxt = nxt ^ poly;
        end
        return nxt & mask;
    endfunction

endpackage

// File: rtl/cell_bist_misr.sv
// Serial-input MISR used to compact the sampled cell response into a signature.
module cell_bist_misr
    import cell_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic             y_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (step_i) begin
            sig_d = SIG_W'(misr_step(SIG_W_MAX'(sig_q), y_i, SIG_W_MAX'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/cell_bist.sv
// Exhaustive-pattern self-test harness for one library cell with MISR response compaction.
// Optional Y-high sample counter enabled by defining CELL_BIST_ONES_CNT_EN.
module cell_bist
    import cell_bist_pkg::*;
#(
    parameter int               STIM_W     = 4,
    parameter int               SETTLE_CYC = 2,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic              Y,
    output logic [STIM_W-1:0] STIM,
    output logic              BUSY,
    output logic              DONE,
    output logic [SIG_W-1:0]  SIG,
    output logic              PASS,
    output logic [STIM_W:0]   ONES_CNT
);

    localparam int                 CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [STIM_W-1:0]  PAT_LAST    = '1;

    state_e            state_q, state_d;
    logic [STIM_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_start;
    logic              misr_step_en;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        pat_d        = pat_q;
        cnt_d        = cnt_q;
        run_start    = 1'b0;
        misr_step_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d   = ST_SETTLE;
                    pat_d     = '0;
                    cnt_d     = '0;
                    run_start = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                misr_step_en = 1'b1;
                if (pat_q == PAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pat_d   = pat_q + 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    cell_bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk    (CLK),
        .rst_n  (CLR),
        .clr_i  (run_start),
        .step_i (misr_step_en),
        .y_i    (Y),
        .sig_o  (SIG)
    );

`ifdef CELL_BIST_ONES_CNT_EN
    logic [STIM_W:0] ones_q, ones_d;

    always_comb begin
        ones_d = ones_q;
        if (run_start) begin
            ones_d = '0;
        end else if (misr_step_en && Y) begin
            ones_d = ones_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign ONES_CNT = ones_q;
`else
    assign ONES_CNT = '0;
`endif

    assign STIM = pat_q;
    assign BUSY = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign DONE = (state_q == ST_DONE);
    assign PASS = DONE && (SIG == GOLDEN);

endmodule

// File: tb/tb_cell_bist.sv
// Randomised self-checking bench for cell_bist: five instances with different widths, settle times and goldens.
module tb_cell_bist;

    localparam int LAT_A = 16 * 3;
    localparam int LAT_B = 4 * 2;
    localparam int LAT_C = 2 * 2;
    localparam int LAT_E = 32 * 3;
    localparam int POLY_I = 16'hB400;

    logic clk = 1'b0;
    logic clr_n;
    logic start;
    logic [15:0] tt_a;
    logic [31:0] tt_e;

    logic [3:0] stim_a; logic busy_a, done_a, pass_a, y_a; logic [15:0] sig_a; logic [4:0] ones_a;
    logic [1:0] stim_b; logic busy_b, done_b, pass_b, y_b; logic [15:0] sig_b; logic [2:0] ones_b;
    logic [0:0] stim_c; logic busy_c, done_c, pass_c, y_c; logic [15:0] sig_c; logic [1:0] ones_c;
    logic [0:0] stim_d; logic busy_d, done_d, pass_d, y_d; logic [15:0] sig_d; logic [1:0] ones_d;
    logic [4:0] stim_e; logic busy_e, done_e, pass_e, y_e; logic [15:0] sig_e; logic [5:0] ones_e;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign y_a = tt_a[stim_a];
    assign y_b = 1'b1;
    assign y_c = ~stim_c[0];
    assign y_d = ~stim_d[0];
    assign y_e = tt_e[stim_e];

    cell_bist #(.STIM_W(4), .SETTLE_CYC(2)) u_a (
        .CLK(clk), .CLR(clr_n), .START(start), .Y(y_a), .STIM(stim_a), .BUSY(busy_a),
        .DONE(done_a), .SIG(sig_a), .PASS(pass_a), .ONES_CNT(ones_a));
    cell_bist #(.STIM_W(2), .SETTLE_CYC(1)) u_b (
        .CLK(clk), .CLR(clr_n), .START(start), .Y(y_b), .STIM(stim_b), .BUSY(busy_b),
        .DONE(done_b), .SIG(sig_b), .PASS(pass_b), .ONES_CNT(ones_b));
    cell_bist #(.STIM_W(1), .SETTLE_CYC(1), .GOLDEN(16'h0002)) u_c (
        .CLK(clk), .CLR(clr_n), .START(start), .Y(y_c), .STIM(stim_c), .BUSY(busy_c),
        .DONE(done_c), .SIG(sig_c), .PASS(pass_c), .ONES_CNT(ones_c));
    cell_bist #(.STIM_W(1), .SETTLE_CYC(1), .GOLDEN(16'h0003)) u_d (
        .CLK(clk), .CLR(clr_n), .START(start), .Y(y_d), .STIM(stim_d), .BUSY(busy_d),
        .DONE(done_d), .SIG(sig_d), .PASS(pass_d), .ONES_CNT(ones_d));
    cell_bist #(.STIM_W(5), .SETTLE_CYC(2)) u_e (
        .CLK(clk), .CLR(clr_n), .START(start), .Y(y_e), .STIM(stim_e), .BUSY(busy_e),
        .DONE(done_e), .SIG(sig_e), .PASS(pass_e), .ONES_CNT(ones_e));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signature as an integer: double, add the sample, fold the overflow bit back through POLY.
    function automatic logic [15:0] ref_sig(input logic [31:0] tt, input int n);
        int s = 0;
        for (int p = 0; p < n; p++) begin
            s = s * 2 + int'(tt[p]);
            if (s >= 65536) s = (s - 65536) ^ POLY_I;
        end
        return 16'(s);
    endfunction

    function automatic int ref_ones(input logic [31:0] tt, input int n);
        int c = 0;
        for (int p = 0; p < n; p++) c += int'(tt[p]);
`ifdef CELL_BIST_ONES_CNT_EN
        return c;
`else
        return c * 0;
`endif
    endfunction

    task automatic check_zero_a(input string tag);
        check({tag, "_stim"}, 32'(stim_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_sig"},  32'(sig_a),  0);
        check({tag, "_pass"}, 32'(pass_a), 0);
        check({tag, "_ones"}, 32'(ones_a), 0);
    endtask

    // One run: START pulse, extra START while busy, then completion checks. rst_at>0 aborts with CLR.
    task automatic run(input bit from_done, input int rst_at);
        int n = 0;
        int cyc_a = -1, cyc_b = -1, cyc_c = -1, cyc_d = -1, cyc_e = -1;
        logic [15:0] exp_sig;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_stim0", 32'(stim_a), 0);
        check("start_busy", 32'(busy_a), 1);
        if (from_done) begin
            check("rerun_clr_sig_a", 32'(sig_a), 0);
            check("rerun_clr_sig_e", 32'(sig_e), 0);
            check("rerun_clr_done", 32'(done_e), 0);
        end
        while (n < 200 && !(done_a && done_b && done_c && done_d && done_e)) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == rst_at) begin
                clr_n = 1'b0;
                #1;
                check_zero_a("rst_mid");
                check("rst_mid_sig_e", 32'(sig_e), 0);
                check("rst_mid_done_c", 32'(done_c), 0);
                @(negedge clk);
                clr_n = 1'b1;
                repeat (3) @(negedge clk);
                check_zero_a("no_resume");
                return;
            end
            if (n == 2) begin
                check("busy_mid", 32'(busy_a), 1);
                start = 1'b1;
            end
            if (n == 3) start = 1'b0;
            if (n <= LAT_A) check("stim_seq_a", 32'(stim_a), (n / 3 > 15) ? 15 : n / 3);
            if (n <= LAT_B && n % 2 == 0) check("sig_step_b", 32'(sig_b), (1 << (n / 2)) - 1);
            if (done_a && cyc_a < 0) cyc_a = n;
            if (done_b && cyc_b < 0) cyc_b = n;
            if (done_c && cyc_c < 0) cyc_c = n;
            if (done_d && cyc_d < 0) cyc_d = n;
            if (done_e && cyc_e < 0) cyc_e = n;
        end
        check("lat_a", 32'(cyc_a), LAT_A);
        check("lat_b", 32'(cyc_b), LAT_B);
        check("lat_c", 32'(cyc_c), LAT_C);
        check("lat_d", 32'(cyc_d), LAT_C);
        check("lat_e", 32'(cyc_e), LAT_E);
        check("busy_end_a", 32'(busy_a), 0);

        exp_sig = ref_sig(32'(tt_a), 16);
        check("sig_a",  32'(sig_a),  32'(exp_sig));
        check("pass_a", 32'(pass_a), 32'(exp_sig == 16'h0000));
        check("ones_a", 32'(ones_a), ref_ones(32'(tt_a), 16));

        check("sig_b",  32'(sig_b),  32'(ref_sig(32'hF, 4)));
        check("pass_b", 32'(pass_b), 0);
        check("ones_b", 32'(ones_b), ref_ones(32'hF, 4));

        check("sig_c",  32'(sig_c),  32'(ref_sig(32'h1, 2)));
        check("pass_c", 32'(pass_c), 1);
        check("sig_d",  32'(sig_d),  32'(ref_sig(32'h1, 2)));
        check("pass_d", 32'(pass_d), 0);
        check("ones_c", 32'(ones_c), ref_ones(32'h1, 2));

        exp_sig = ref_sig(tt_e, 32);
        check("sig_e",  32'(sig_e),  32'(exp_sig));
        check("pass_e", 32'(pass_e), 32'(exp_sig == 16'h0000));
        check("ones_e", 32'(ones_e), ref_ones(tt_e, 32));

        // Idle DONE holds its results for a few cycles.
        repeat (3) @(negedge clk);
        check("hold_sig_e", 32'(sig_e), 32'(exp_sig));
        check("hold_done_a", 32'(done_a), 1);
    endtask

    initial begin
        logic [4:0] pv;
        clr_n = 1'b0;
        start = 1'b0;
        tt_a  = '0;
        tt_e  = '0;
        repeat (2) @(negedge clk);
        check_zero_a("reset");
        check("reset_done_c", 32'(done_c), 0);
        clr_n = 1'b1;
        @(negedge clk);
        check_zero_a("post_reset");

        // Constant-zero cell on A; two-input AND on E to drive the MISR into feedback.
        for (int p = 0; p < 32; p++) begin
            pv = 5'(p);
            tt_e[p] = pv[0] & pv[1];
        end
        run(1'b0, 0);

        for (int r = 0; r < 4; r++) begin
            tt_a = 16'($urandom);
            tt_e = $urandom;
            run(1'b1, 0);
        end
        run(1'b1, 0);

        run(1'b1, 10);

        tt_a = 16'($urandom);
        tt_e = $urandom;
        run(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
